// File: rtl/audacq_fifo.sv
// rtl/audacq_fifo.sv - audio sample FIFO between the acquisition controller and the femto bus
// Parameters: DEPTH_LOG2 - FIFO depth is 2**DEPTH_LOG2 entries (1..7).
// Ports: clk, rstn (synchronous, active-low)
//        in_vld, in_sample[15:0]         - sample strobe and signed sample
//        req, addr[3:0], w_rb, acc, wdata - bus request (DR @0 RO, SR @4 RO, CR @8 WO)
//        rdata, resp                      - registered bus response
//        fault                            - combinational, request with an invalid access
//        irq                              - registered level interrupt (threshold / overflow)
// Build option: AUDACQ_FIFO_OVERWRITE_EN - a push when full overwrites the oldest entry.
module audacq_fifo #(
    parameter int DEPTH_LOG2 = 5,
    localparam int BUS_WIDTH = 32,
    localparam int BUS_ACC_WIDTH = 2,
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_vld,
    input  logic [15:0]              in_sample,
    input  logic [3:0]               addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     rdata,
    input  logic [BUS_WIDTH-1:0]     wdata,
    input  logic                     req,
    output logic                     resp,
    output logic                     fault,
    output logic                     irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  ovf;
    logic                  ie;
    logic [7:0]            thr;

    logic             bad_access;
    logic             valid_req;
    logic             dr_rd;
    logic             sr_rd;
    logic             cr_wr;
    logic             flush;
    logic             ovf_clr;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             full_hit;
    logic             rd_adv;
    logic [LVL_W-1:0] level_nxt;
    logic             ovf_nxt;
    logic             ie_nxt;
    logic [7:0]       thr_nxt;
    logic             irq_nxt;

    // Once addr is word aligned and <= 8 it is one of DR/SR/CR, and addr[3]
    // alone marks CR; the only legal direction is write for CR, read otherwise.
    assign bad_access = (addr[1:0] != 2'b00) || (acc != BUS_ACC_4B) || (addr > 4'd8)
                      || (w_rb != addr[3]);

    assign fault     = req && bad_access;
    assign valid_req = req && !bad_access;
    assign dr_rd     = valid_req && !w_rb && !addr[2];
    assign sr_rd     = valid_req && !w_rb && addr[2];
    assign cr_wr     = valid_req && w_rb;
    assign flush     = cr_wr && wdata[31];
    assign ovf_clr   = cr_wr && wdata[30];

    assign full      = (level == LVL_FULL);
    assign empty     = (level == '0);
    assign pop       = dr_rd && !empty;
    assign push_req  = in_vld && !flush;
    // A same-cycle pop frees a slot, so only a push without a pop overflows.
    assign full_hit  = push_req && full && !pop;

`ifdef AUDACQ_FIFO_OVERWRITE_EN
    assign push   = push_req;
    assign rd_adv = pop || full_hit;
`else
    assign push   = push_req && !full_hit;
    assign rd_adv = pop;
`endif

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !rd_adv) begin
            level_nxt = level + LVL_ONE;
        end else if (!push && rd_adv) begin
            level_nxt = level - LVL_ONE;
        end
    end

    // Overflow set takes priority over a same-cycle clear.
    assign ovf_nxt = full_hit || (ovf && !ovf_clr);
    assign ie_nxt  = cr_wr ? wdata[16]   : ie;
    assign thr_nxt = cr_wr ? wdata[7:0]  : thr;
    assign irq_nxt = ie_nxt && (((thr_nxt != 8'd0) && (8'(level_nxt) >= thr_nxt)) || ovf_nxt);

    // Sample storage carries no reset; only pointers and level define contents.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            ie     <= 1'b0;
            thr    <= 8'd0;
            irq    <= 1'b0;
            resp   <= 1'b0;
            rdata  <= '0;
        end else begin
            resp  <= valid_req;
            level <= level_nxt;
            ovf   <= ovf_nxt;
            ie    <= ie_nxt;
            thr   <= thr_nxt;
            irq   <= irq_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            if (dr_rd) begin
                rdata <= pop ? {1'b1, 15'd0, mem[rd_ptr]} : '0;
            end else if (sr_rd) begin
                rdata <= {ovf, full, empty, 21'd0, 8'(level)};
            end
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^{wdata[29:17], wdata[15:8]};

endmodule

// File: tb/tb_audacq_fifo.sv
// tb/tb_audacq_fifo.sv - self-checking bench for audacq_fifo (DEPTH_LOG2=2)
module tb_audacq_fifo;

    localparam int DL2 = 2;
    localparam int DEPTH = 1 << DL2;
    localparam logic [1:0] ACC4 = 2'd2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_vld;
    logic [15:0] in_sample;
    logic [3:0]  addr;
    logic        w_rb;
    logic [1:0]  acc;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        req;
    logic        resp;
    logic        fault;
    logic        irq;

    always #5 clk = ~clk;

    audacq_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_sample(in_sample),
        .addr(addr), .w_rb(w_rb), .acc(acc), .rdata(rdata), .wdata(wdata),
        .req(req), .resp(resp), .fault(fault), .irq(irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of samples plus the software-visible flags.
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_ie;
    logic [7:0]  m_thr;
    logic [31:0] m_rdata;
    logic        m_resp;
    logic        m_irq;

    typedef struct {
        logic        v;
        logic [15:0] s;
        logic        rq;
        logic        w;
        logic [3:0]  a;
        logic [1:0]  ac;
        logic [31:0] wd;
        logic        e_fault;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic        e_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_ie    = 1'b0;
        m_thr   = 8'd0;
        m_rdata = 32'd0;
        m_resp  = 1'b0;
        m_irq   = 1'b0;
    endtask

    // One clock cycle: drive inputs, check fault combinationally, advance the
    // model, then check the registered outputs after the edge.
    task automatic step(input logic v, input logic [15:0] s, input logic rq, input logic w,
                        input logic [3:0] a, input logic [1:0] ac, input logic [31:0] wd,
                        output logic f_seen);
        logic bad, dr, sr, cr;
        logic [31:0] sr_val;
        in_vld = v; in_sample = s; req = rq; w_rb = w; addr = a; acc = ac; wdata = wd;
        bad = (a[1:0] != 2'd0) || (ac != ACC4) || (a > 4'd8)
              || (w && (a == 4'd0 || a == 4'd4)) || (!w && a == 4'd8);
        #1;
        f_seen = fault;
        check("fault", fault, rq && bad);
        dr = rq && !bad && !w && a == 4'd0;
        sr = rq && !bad && !w && a == 4'd4;
        cr = rq && !bad && w && a == 4'd8;
        sr_val = {m_ovf, mq.size() == DEPTH, mq.size() == 0, 21'd0, 8'(mq.size())};
        m_resp = rq && !bad;
        if (sr) m_rdata = sr_val;
        if (dr) begin
            if (mq.size() > 0) m_rdata = {1'b1, 15'd0, mq.pop_front()};
            else m_rdata = 32'd0;
        end
        if (cr) begin
            m_ie  = wd[16];
            m_thr = wd[7:0];
            if (wd[30]) m_ovf = 1'b0;
        end
        if (cr && wd[31]) begin
            mq.delete();
        end else if (v) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(s);
            end else begin
                m_ovf = 1'b1;
`ifdef AUDACQ_FIFO_OVERWRITE_EN
                void'(mq.pop_front());
                mq.push_back(s);
`endif
            end
        end
        m_irq = m_ie && (((m_thr != 8'd0) && (mq.size() >= int'(m_thr))) || m_ovf);
        @(posedge clk);
        #1;
        check("resp", resp, m_resp);
        check("rdata", rdata, m_rdata);
        check("irq", irq, m_irq);
    endtask

    function automatic vec_t mk(input logic v, input logic [15:0] s, input logic rq, input logic w,
                                input logic [3:0] a, input logic [1:0] ac, input logic [31:0] wd,
                                input logic ef, input logic er, input logic [31:0] erd, input logic ei);
        vec_t t;
        t.v = v; t.s = s; t.rq = rq; t.w = w; t.a = a; t.ac = ac; t.wd = wd;
        t.e_fault = ef; t.e_resp = er; t.e_rdata = erd; t.e_irq = ei;
        return t;
    endfunction

    function automatic vec_t push(input logic [15:0] s, input logic [31:0] erd, input logic ei);
        return mk(1'b1, s, 1'b0, 1'b0, 4'd0, ACC4, 32'd0, 1'b0, 1'b0, erd, ei);
    endfunction

    function automatic vec_t rd(input logic [3:0] a, input logic [31:0] erd, input logic ei);
        return mk(1'b0, 16'd0, 1'b1, 1'b0, a, ACC4, 32'd0, 1'b0, 1'b1, erd, ei);
    endfunction

    function automatic vec_t wr(input logic [31:0] wd, input logic [31:0] erd, input logic ei);
        return mk(1'b0, 16'd0, 1'b1, 1'b1, 4'd8, ACC4, wd, 1'b0, 1'b1, erd, ei);
    endfunction

    initial begin
        logic        fs;
        logic [31:0] wd;
        logic        v, rq, w;
        logic [3:0]  a;
        logic [1:0]  ac;
        int          op;

        rstn = 1'b0; in_vld = 1'b0; in_sample = 16'd0; req = 1'b0;
        w_rb = 1'b0; addr = 4'd0; acc = ACC4; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'd0);
        check("reset_resp", resp, 1'b0);
        check("reset_irq", irq, 1'b0);
        rstn = 1'b1;
        model_reset();

        // Basic ordering and empty read
        tbl.push_back(push(16'h1234, 32'h0, 1'b0));
        tbl.push_back(push(16'h8001, 32'h0, 1'b0));
        tbl.push_back(push(16'h7FFF, 32'h0, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80001234, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80008001, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80007FFF, 1'b0));
        tbl.push_back(rd(4'd0, 32'h00000000, 1'b0));
        tbl.push_back(rd(4'd4, 32'h20000000, 1'b0));
        // Overflow on a depth-4 FIFO
        for (int i = 0; i < 5; i++) tbl.push_back(push(16'(i), 32'h20000000, 1'b0));
        tbl.push_back(rd(4'd4, 32'hC0000004, 1'b0));
`ifdef AUDACQ_FIFO_OVERWRITE_EN
        for (int i = 1; i < 5; i++) tbl.push_back(rd(4'd0, 32'h80000000 | 32'(i), 1'b0));
`else
        for (int i = 0; i < 4; i++) tbl.push_back(rd(4'd0, 32'h80000000 | 32'(i), 1'b0));
`endif
        tbl.push_back(rd(4'd4, 32'hA0000000, 1'b0));
        tbl.push_back(wr(32'h40000000, 32'hA0000000, 1'b0));
        tbl.push_back(rd(4'd4, 32'h20000000, 1'b0));
        // Threshold interrupt
        tbl.push_back(wr(32'h00010003, 32'h20000000, 1'b0));
        tbl.push_back(push(16'h000A, 32'h20000000, 1'b0));
        tbl.push_back(push(16'h000B, 32'h20000000, 1'b0));
        tbl.push_back(push(16'h000C, 32'h20000000, 1'b1));
        tbl.push_back(rd(4'd0, 32'h8000000A, 1'b0));
        tbl.push_back(rd(4'd0, 32'h8000000B, 1'b0));
        tbl.push_back(rd(4'd0, 32'h8000000C, 1'b0));
        tbl.push_back(wr(32'h00000000, 32'h8000000C, 1'b0));
        // Push and pop together while full
        tbl.push_back(push(16'h0011, 32'h8000000C, 1'b0));
        tbl.push_back(push(16'h0022, 32'h8000000C, 1'b0));
        tbl.push_back(push(16'h0033, 32'h8000000C, 1'b0));
        tbl.push_back(push(16'h0044, 32'h8000000C, 1'b0));
        tbl.push_back(mk(1'b1, 16'h0055, 1'b1, 1'b0, 4'd0, ACC4, 32'd0, 1'b0, 1'b1, 32'h80000011, 1'b0));
        tbl.push_back(rd(4'd4, 32'h40000004, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80000022, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80000033, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80000044, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80000055, 1'b0));
        tbl.push_back(rd(4'd4, 32'h20000000, 1'b0));
        // Flush + overflow clear with a concurrent push
        for (int i = 0; i < 5; i++) tbl.push_back(push(16'hA1 + 16'(i), 32'h20000000, 1'b0));
        tbl.push_back(mk(1'b1, 16'h0099, 1'b1, 1'b1, 4'd8, ACC4, 32'hC0000000, 1'b0, 1'b1, 32'h20000000, 1'b0));
        tbl.push_back(rd(4'd4, 32'h20000000, 1'b0));
        tbl.push_back(rd(4'd0, 32'h00000000, 1'b0));
        // Bus faults must leave state untouched
        tbl.push_back(push(16'h5A5A, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 4'd8, ACC4, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b1, 4'd0, ACC4, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b1, 4'd4, ACC4, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 4'd0, 2'd1, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b1, 4'd8, 2'd0, 32'h00010001, 1'b1, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 4'd2, ACC4, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b1, 1'b0, 4'd12, ACC4, 32'd0, 1'b1, 1'b0, 32'h0, 1'b0));
        tbl.push_back(rd(4'd4, 32'h00000001, 1'b0));
        tbl.push_back(rd(4'd0, 32'h80005A5A, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].rq, tbl[i].w, tbl[i].a, tbl[i].ac, tbl[i].wd, fs);
            check($sformatf("vec%0d_fault", i), fs, tbl[i].e_fault);
            check($sformatf("vec%0d_resp", i), resp, tbl[i].e_resp);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
            check($sformatf("vec%0d_irq", i), irq, tbl[i].e_irq);
        end

        // Mid-operation reset discards queued samples; first push afterwards is kept
        step(1'b1, 16'h0F0F, 1'b0, 1'b0, 4'd0, ACC4, 32'd0, fs);
        step(1'b1, 16'h0E0E, 1'b0, 1'b0, 4'd0, ACC4, 32'd0, fs);
        in_vld = 1'b0; req = 1'b0; rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_resp", resp, 1'b0);
        rstn = 1'b1;
        model_reset();
        step(1'b1, 16'h4321, 1'b0, 1'b0, 4'd0, ACC4, 32'd0, fs);
        step(1'b0, 16'd0, 1'b1, 1'b0, 4'd0, ACC4, 32'd0, fs);
        check("after_reset_pop", rdata, 32'h80004321);

        // Randomised traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 9) < 6);
            rq = $urandom_range(0, 1);
            op = $urandom_range(0, 19);
            w = 1'b0; a = 4'd0; ac = ACC4; wd = $urandom;
            if (op < 8) begin
                a = 4'd0;
            end else if (op < 13) begin
                a = 4'd4;
            end else if (op < 16) begin
                w = 1'b1; a = 4'd8;
                wd[31] = ($urandom_range(0, 15) == 0);
                wd[30] = ($urandom_range(0, 3) == 0);
                wd[7:0] = 8'($urandom_range(0, DEPTH + 1));
            end else begin
                w  = 1'($urandom_range(0, 1));
                a  = 4'($urandom_range(0, 15));
                ac = 2'($urandom_range(0, 3));
            end
            if (c == 1500) begin
                in_vld = 1'b0; req = 1'b0; rstn = 1'b0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
                model_reset();
            end
            step(v, 16'($urandom), rq, w, a, ac, wd, fs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
